// File: rtl/mips_pkg.sv
// Shared types and instruction field layout for the 16-bit MIPS-like cores.
package mips_pkg;

    localparam int unsigned InstrW  = 16;
    localparam int unsigned OpW     = 3;
    localparam int unsigned OpLsb   = 13;
    localparam int unsigned RegAw   = 3;
    localparam int unsigned NumRegs = 8;
    localparam int unsigned RaLsb   = 10;
    localparam int unsigned RbLsb   = 7;
    localparam int unsigned RcLsb   = 4;
    localparam int unsigned ImmW    = 7;

    typedef enum logic [OpW-1:0] {
        OpLw   = 3'b000,
        OpSw   = 3'b001,
        OpAdd  = 3'b010,
        OpSub  = 3'b011,
        OpBeq  = 3'b100,
        OpAddi = 3'b101,
        OpRsvd = 3'b110,
        OpHalt = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd5
    } state_e;

endpackage

// File: rtl/mips_regfile.sv
// 8-entry register file: three asynchronous read ports, one synchronous write port.
// Entry 0 is never written, so it always reads zero.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [RegAw-1:0]  i_raddr_a,
    input  logic [RegAw-1:0]  i_raddr_b,
    input  logic [RegAw-1:0]  i_raddr_c,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_c,
    input  logic              i_we,
    input  logic [RegAw-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_regs [NumRegs];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];
    assign o_rdata_c = r_regs[i_raddr_c];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle 16-bit MIPS-like core: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack
// handshakes to instruction and data memories, plus halt/retire status for the harness.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IADDR_W  = 5,
    parameter int unsigned DADDR_W  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    output logic               o_imem_req,
    output logic [IADDR_W-1:0] o_imem_addr,
    input  logic [InstrW-1:0]  i_imem_rdata,
    input  logic               i_imem_ack,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [DADDR_W-1:0] o_dmem_addr,
    output logic [DATA_W-1:0]  o_dmem_wdata,
    input  logic [DATA_W-1:0]  i_dmem_rdata,
    input  logic               i_dmem_ack,
    input  logic               i_resume,
    output logic [IADDR_W-1:0] o_pc,
    output logic               o_retire,
    output logic               o_branch_taken,
    output logic               o_halt,
    output logic               o_illegal
);

    localparam logic [IADDR_W-1:0] ResetPc = IADDR_W'(RESET_PC);

    state_e             r_state, w_state_d;
    logic [IADDR_W-1:0] r_pc, w_pc_d, w_pc_inc, w_imm_pc;
    logic [InstrW-1:0]  r_instr, w_instr_d;
    logic [DATA_W-1:0]  r_op_a, r_op_b, r_op_c, w_op_a_d, w_op_b_d, w_op_c_d;
    logic [DATA_W-1:0]  r_result, w_result_d, w_imm_data;
    logic [DATA_W-1:0]  w_rf_a, w_rf_b, w_rf_c;
    logic               r_retire, w_retire_d, r_taken, w_taken_d, r_illegal, w_illegal_d;
    logic               w_rf_we;
    opcode_e            w_op;
    logic [RegAw-1:0]   w_ra, w_rb, w_rc;

    assign w_op       = opcode_e'(r_instr[OpLsb +: OpW]);
    assign w_ra       = r_instr[RaLsb +: RegAw];
    assign w_rb       = r_instr[RbLsb +: RegAw];
    assign w_rc       = r_instr[RcLsb +: RegAw];
    assign w_imm_data = DATA_W'($signed(r_instr[ImmW-1:0]));
    assign w_imm_pc   = IADDR_W'($signed(r_instr[ImmW-1:0]));
    assign w_pc_inc   = r_pc + IADDR_W'(1);

    mips_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_reset),
        .i_raddr_a (w_ra),
        .i_raddr_b (w_rb),
        .i_raddr_c (w_rc),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b),
        .o_rdata_c (w_rf_c),
        .i_we      (w_rf_we),
        .i_waddr   (w_ra),
        .i_wdata   (r_result)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StFetch;
            r_pc      <= ResetPc;
            r_instr   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_c    <= '0;
            r_result  <= '0;
            r_retire  <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_instr   <= w_instr_d;
            r_op_a    <= w_op_a_d;
            r_op_b    <= w_op_b_d;
            r_op_c    <= w_op_c_d;
            r_result  <= w_result_d;
            r_retire  <= w_retire_d;
            r_taken   <= w_taken_d;
            r_illegal <= w_illegal_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_instr_d   = r_instr;
        w_op_a_d    = r_op_a;
        w_op_b_d    = r_op_b;
        w_op_c_d    = r_op_c;
        w_result_d  = r_result;
        w_retire_d  = 1'b0;
        w_taken_d   = 1'b0;
        w_illegal_d = r_illegal;
        w_rf_we     = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (i_imem_ack) begin
                    w_instr_d = i_imem_rdata;
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                w_op_a_d = w_rf_a;
                w_op_b_d = w_rf_b;
                w_op_c_d = w_rf_c;
                if (w_op == OpHalt) begin
                    w_retire_d = 1'b1;
                    w_state_d  = StHalted;
                end else begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                w_state_d = StWb;
                unique case (w_op)
                    OpBeq: begin
                        w_retire_d = 1'b1;
                        w_state_d  = StFetch;
                        if (r_op_a == r_op_b) begin
                            w_pc_d    = w_pc_inc + w_imm_pc;
                            w_taken_d = 1'b1;
                        end else begin
                            w_pc_d = w_pc_inc;
                        end
                    end
                    OpRsvd: begin
                        w_illegal_d = 1'b1;
                        w_retire_d  = 1'b1;
                        w_pc_d      = w_pc_inc;
                        w_state_d   = StFetch;
                    end
                    OpLw, OpSw: w_state_d  = StMem;
                    OpAdd:      w_result_d = r_op_b + r_op_c;
                    OpSub:      w_result_d = r_op_b - r_op_c;
                    OpAddi:     w_result_d = r_op_b + w_imm_data;
                    default:    w_state_d  = StFetch;
                endcase
            end
            StMem: begin
                if (i_dmem_ack) begin
                    if (w_op == OpSw) begin
                        w_pc_d     = w_pc_inc;
                        w_retire_d = 1'b1;
                        w_state_d  = StFetch;
                    end else begin
                        w_result_d = i_dmem_rdata;
                        w_state_d  = StWb;
                    end
                end
            end
            StWb: begin
                w_rf_we    = 1'b1;
                w_pc_d     = w_pc_inc;
                w_retire_d = 1'b1;
                w_state_d  = StFetch;
            end
            StHalted: begin
                if (i_resume) begin
                    w_pc_d    = w_pc_inc;
                    w_state_d = StFetch;
                end
            end
            default: w_state_d = StFetch;
        endcase
    end

    // Requests are gated by reset so they drop in the same cycle reset is raised.
    assign o_imem_req     = (r_state == StFetch) && !i_reset;
    assign o_imem_addr    = r_pc;
    assign o_dmem_req     = (r_state == StMem) && !i_reset;
    assign o_dmem_we      = o_dmem_req && (w_op == OpSw);
    assign o_dmem_addr    = r_instr[DADDR_W-1:0];
    assign o_dmem_wdata   = r_op_a;
    assign o_pc           = r_pc;
    assign o_retire       = r_retire;
    assign o_branch_taken = r_taken;
    assign o_halt         = (r_state == StHalted);
    assign o_illegal      = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: behavioural imem/dmem with programmable ack
// delay, a store scoreboard and a retire log checked against hand-derived expectations.
module tb_mips_multicycle_core;

    localparam logic [2:0] OpLw = 3'd0, OpSw = 3'd1, OpAdd = 3'd2, OpSub = 3'd3;
    localparam logic [2:0] OpBeq = 3'd4, OpAddi = 3'd5, OpRsvd = 3'd6, OpHalt = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [4:0]  imem_addr, pc;
    logic [15:0] imem_rdata;
    logic [3:0]  dmem_addr;
    logic [7:0]  dmem_wdata, dmem_rdata;
    logic        resume = 1'b0;
    logic        retire, branch_taken, halt, illegal;
    logic        force_dack = 1'b0;

    logic [15:0] imem [32];
    logic [7:0]  dmem [16];
    int          idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;
    int          n_checks = 0, n_err = 0, cyc = 0, t0 = 0, bt_cnt = 0;
    logic [11:0] exp_store [$];
    logic [4:0]  ret_pc [$];
    logic        ret_bt [$];
    int          ret_cyc [$];
    logic        d_hold = 1'b0;
    logic [12:0] d_snap = '0;

    mips_multicycle_core u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_rdata   (imem_rdata),
        .i_imem_ack     (imem_ack),
        .o_dmem_req     (dmem_req),
        .o_dmem_we      (dmem_we),
        .o_dmem_addr    (dmem_addr),
        .o_dmem_wdata   (dmem_wdata),
        .i_dmem_rdata   (dmem_rdata),
        .i_dmem_ack     (dmem_ack),
        .i_resume       (resume),
        .o_pc           (pc),
        .o_retire       (retire),
        .o_branch_taken (branch_taken),
        .o_halt         (halt),
        .o_illegal      (illegal)
    );

    initial forever #5 clk = ~clk;

    assign imem_ack   = imem_req && (icnt >= idelay);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = (dmem_req && (dcnt >= ddelay)) || force_dack;
    assign dmem_rdata = dmem[dmem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins_i(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic logic [15:0] ins_r(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, c, 4'b0000};
    endfunction

    // Wait counters advance on the clock edge; the ack they gate is stable all cycle.
    initial forever begin
        @(posedge clk);
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end

    // Mid-cycle monitor: retire log, handshake stability, store scoreboard.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (retire) begin
            ret_pc.push_back(pc);
            ret_bt.push_back(branch_taken);
            ret_cyc.push_back(cyc);
        end
        if (branch_taken) bt_cnt++;
        if (dmem_req) begin
            if (d_hold) chk("dmem_stable", 32'(d_snap), 32'({dmem_we, dmem_addr, dmem_wdata}));
            d_snap = {dmem_we, dmem_addr, dmem_wdata};
            d_hold = !dmem_ack;
            if (dmem_ack && dmem_we) begin
                dmem[dmem_addr] = dmem_wdata;
                if (exp_store.size() == 0) begin
                    chk("store_extra", 32'({dmem_addr, dmem_wdata}), 32'hFFFF_FFFF);
                end else begin
                    chk("store", 32'({dmem_addr, dmem_wdata}), 32'(exp_store.pop_front()));
                end
            end
        end else begin
            d_hold = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic load_clear();
        for (int i = 0; i < 32; i++) imem[i] = {OpHalt, 13'd0};
        for (int i = 0; i < 16; i++) dmem[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        resume = 1'b0;
        force_dack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_pc", 32'({imem_addr, pc}), 0);
        chk("rst_outs", 32'({dmem_req, dmem_we, dmem_addr, dmem_wdata, retire, branch_taken,
                             halt, illegal}), 0);
        ret_pc.delete();
        ret_bt.delete();
        ret_cyc.delete();
        bt_cnt = 0;
        reset = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_halt(input int max_cyc);
        int n = 0;
        while (!halt && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("halt_reached", 32'(halt), 1);
    endtask

    task automatic wait_retires(input int cnt, input int max_cyc);
        int n = 0;
        while (ret_pc.size() < cnt && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("retire_reached", 32'(ret_pc.size() >= cnt), 1);
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        @(negedge clk);
        #1;
        resume = 1'b0;
    endtask

    initial begin
        // 1: ADDI r1,r0,5; HALT; then resume into SW r1 -> dmem[0]
        load_clear();
        imem[0] = ins_i(OpAddi, 3'd1, 3'd0, 7'd5);
        imem[2] = ins_i(OpSw, 3'd1, 3'd0, 7'd0);
        exp_store.push_back({4'd0, 8'd5});
        do_reset();
        wait_halt(40);
        chk("t1_halt_cycle", 32'(cyc - t0), 6);
        chk("t1_pc", 32'(pc), 1);
        chk("t1_retires", 32'(ret_pc.size()), 2);
        chk("t1_addi_lat", 32'(ret_cyc[0] - t0), 4);
        pulse_resume();
        wait_halt(40);
        chk("t1_resume_pc", 32'(pc), 3);
        chk("t1_store_left", 32'(exp_store.size()), 0);

        // 2: sign-extended imm, wrap-around ADD, r0 hardwired; resume ignored while running
        load_clear();
        imem[0] = ins_i(OpAddi, 3'd1, 3'd0, 7'h7F);
        imem[1] = ins_r(OpAdd, 3'd2, 3'd1, 3'd1);
        imem[2] = ins_i(OpAddi, 3'd0, 3'd0, 7'd3);
        imem[3] = ins_i(OpSw, 3'd2, 3'd0, 7'd1);
        imem[4] = ins_i(OpSw, 3'd0, 3'd0, 7'd2);
        imem[5] = ins_r(OpSub, 3'd3, 3'd0, 3'd1);
        imem[6] = ins_i(OpSw, 3'd3, 3'd0, 7'd3);
        exp_store.push_back({4'd1, 8'hFE});
        exp_store.push_back({4'd2, 8'h00});
        exp_store.push_back({4'd3, 8'h01});
        do_reset();
        resume = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        resume = 1'b0;
        wait_halt(80);
        chk("t2_halt_cycle", 32'(cyc - t0), 30);
        chk("t2_pc", 32'(pc), 7);
        chk("t2_add_lat", 32'(ret_cyc[1] - ret_cyc[0]), 4);
        chk("t2_store_left", 32'(exp_store.size()), 0);

        // 3: SW/LW with two wait cycles on dmem
        load_clear();
        ddelay = 2;
        dmem[7] = 8'h99;
        imem[0] = ins_i(OpAddi, 3'd1, 3'd0, 7'd42);
        imem[1] = ins_i(OpSw, 3'd1, 3'd0, 7'd3);
        imem[2] = ins_i(OpLw, 3'd4, 3'd0, 7'd3);
        imem[3] = ins_i(OpSw, 3'd4, 3'd0, 7'd5);
        imem[4] = ins_i(OpLw, 3'd5, 3'd0, 7'd7);
        imem[5] = ins_i(OpSw, 3'd5, 3'd0, 7'd8);
        exp_store.push_back({4'd3, 8'h2A});
        exp_store.push_back({4'd5, 8'h2A});
        exp_store.push_back({4'd8, 8'h99});
        do_reset();
        wait_halt(120);
        chk("t3_sw_lat", 32'(ret_cyc[1] - ret_cyc[0]), 6);
        chk("t3_lw_lat", 32'(ret_cyc[2] - ret_cyc[1]), 7);
        chk("t3_halt_cycle", 32'(cyc - t0), 38);
        chk("t3_pc", 32'(pc), 6);
        chk("t3_store_left", 32'(exp_store.size()), 0);
        ddelay = 0;

        // 4a: BEQ r0,r0,-1 loops on itself
        load_clear();
        imem[0] = ins_i(OpBeq, 3'd0, 3'd0, 7'h7F);
        do_reset();
        wait_retires(2, 40);
        chk("t4a_pc", 32'(ret_pc[0]), 0);
        chk("t4a_taken", 32'(ret_bt[0]), 1);
        chk("t4a_lat", 32'(ret_cyc[0] - t0), 3);
        chk("t4a_lat2", 32'(ret_cyc[1] - ret_cyc[0]), 3);
        chk("t4a_bt_pulses", 32'(bt_cnt), 2);

        // 4b: not-taken BEQ, forward branch to pc 31, then wrap to 0
        load_clear();
        imem[0]  = ins_i(OpAddi, 3'd1, 3'd0, 7'd1);
        imem[1]  = ins_i(OpBeq, 3'd1, 3'd0, 7'd5);
        imem[2]  = ins_i(OpBeq, 3'd0, 3'd0, 7'd28);
        imem[31] = ins_i(OpBeq, 3'd0, 3'd0, 7'd0);
        do_reset();
        wait_retires(4, 60);
        chk("t4b_pc_seq", 32'({ret_pc[0], ret_pc[1], ret_pc[2], ret_pc[3]}),
            32'({5'd1, 5'd2, 5'd31, 5'd0}));
        chk("t4b_bt_seq", 32'({ret_bt[0], ret_bt[1], ret_bt[2], ret_bt[3]}), 32'(4'b0011));
        chk("t4b_wrap_cycle", 32'(ret_cyc[3] - t0), 13);

        // 6: reserved opcode sets sticky illegal; HALT then resume continues at pc+1
        load_clear();
        imem[0] = {OpRsvd, 13'd0};
        imem[2] = ins_i(OpAddi, 3'd1, 3'd0, 7'd7);
        imem[3] = ins_i(OpSw, 3'd1, 3'd0, 7'd9);
        exp_store.push_back({4'd9, 8'd7});
        do_reset();
        wait_retires(1, 20);
        chk("t6_illegal_set", 32'(illegal), 1);
        chk("t6_nop_pc", 32'(ret_pc[0]), 1);
        chk("t6_nop_lat", 32'(ret_cyc[0] - t0), 3);
        wait_halt(20);
        chk("t6_halt_pc", 32'(pc), 1);
        pulse_resume();
        wait_halt(40);
        chk("t6_resume_pc", 32'(pc), 4);
        chk("t6_illegal_sticky", 32'(illegal), 1);
        chk("t6_store_left", 32'(exp_store.size()), 0);

        // 5: reset during a stalled load, then a stray dmem ack while fetching
        load_clear();
        ddelay = 20;
        dmem[2] = 8'h5C;
        imem[0] = ins_i(OpAddi, 3'd1, 3'd0, 7'd1);
        imem[1] = ins_i(OpLw, 3'd2, 3'd0, 7'd2);
        imem[2] = ins_i(OpSw, 3'd2, 3'd0, 7'd4);
        do_reset();
        for (int i = 0; i < 20 && !dmem_req; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t5_in_mem", 32'(dmem_req), 1);
        chk("t5_pc_before", 32'(pc), 1);
        reset = 1'b1;
        #1;
        chk("t5_req_drop", 32'(dmem_req), 0);
        chk("t5_pc_reset", 32'(pc), 0);
        idelay = 30;
        @(negedge clk);
        #1;
        reset = 1'b0;
        ret_pc.delete();
        ret_bt.delete();
        ret_cyc.delete();
        force_dack = 1'b1;
        @(negedge clk);
        #1;
        force_dack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_stray_ack", 32'({dmem_req, imem_req, pc}), 32'({1'b0, 1'b1, 5'd0}));
        chk("t5_no_retire", 32'(ret_pc.size()), 0);
        exp_store.push_back({4'd4, 8'h5C});
        idelay = 0;
        ddelay = 0;
        wait_halt(80);
        chk("t5_final_pc", 32'(pc), 3);
        chk("t5_store_left", 32'(exp_store.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
